// File: rtl/axi_to_conv_stream.sv
// axi_to_conv_stream: splits one AXI-stream beat into NUM_BLOCKS independently handshaked lanes,
// zeroing disabled bytes and marking absent lanes of a final beat as empty end-of-packet markers.
module axi_to_conv_stream #(
   parameter int BLOCK_SIZE = 128,
   parameter int NUM_BLOCKS = 8
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   output logic                                  in_ready,
   input  logic [NUM_BLOCKS*BLOCK_SIZE-1:0]      in_data,
   input  logic [NUM_BLOCKS*BLOCK_SIZE/8-1:0]    in_keep,
   input  logic                                  in_valid,
   input  logic                                  in_last,
   input  logic [NUM_BLOCKS-1:0]                 out_ready,
   output logic [NUM_BLOCKS-1:0][BLOCK_SIZE-1:0] out_data,
   output logic [NUM_BLOCKS-1:0]                 out_valid,
   output logic [NUM_BLOCKS-1:0]                 out_last,
   output logic [NUM_BLOCKS-1:0]                 out_empty,
   output logic [31:0]                           pkt_count,
   output logic                                  keep_err
);
   localparam int KB = BLOCK_SIZE/8;
   localparam int KW = NUM_BLOCKS*KB;
   logic [NUM_BLOCKS-1:0][BLOCK_SIZE-1:0] r_data, w_masked;
   logic [NUM_BLOCKS-1:0] r_p, r_e, w_present, w_hs, w_p_next;
   logic [KW-1:0] w_keep_inc;
   logic r_l, r_full, w_accept, w_done, w_keep_bad;
   for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_lane
      assign w_present[i] = |in_keep[i*KB +: KB];
      for (genvar j = 0; j < KB; j++) begin : g_byte
         assign w_masked[i][j*8 +: 8] = in_keep[i*KB+j] ? in_data[(i*KB+j)*8 +: 8] : 8'h00;
      end
   end
   assign out_valid  = {NUM_BLOCKS{r_full}} & r_p;
   assign out_last   = out_valid & {NUM_BLOCKS{r_l}};
   assign out_empty  = out_valid & r_e;
   assign out_data   = r_data;
   assign w_hs       = out_valid & out_ready;
   assign w_p_next   = r_p & ~w_hs;
   assign in_ready   = rst_n & (~r_full | ((r_p & ~out_ready) == '0));
   assign w_accept   = in_valid & in_ready;
   assign w_done     = r_full & r_l & (w_hs != '0) & (w_p_next == '0);
   // a prefix mask 2^k-1 has no overlap with itself plus one
   assign w_keep_inc = in_keep + KW'(1);
   assign w_keep_bad = (in_keep & w_keep_inc) != '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data    <= '0;
         r_p       <= '0;
         r_e       <= '0;
         r_l       <= 1'b0;
         r_full    <= 1'b0;
         pkt_count <= '0;
         keep_err  <= 1'b0;
      end else begin
         if (w_done) pkt_count <= pkt_count + 32'd1;
         if (w_accept && w_keep_bad) keep_err <= 1'b1;
         if (w_accept) begin
            r_data <= w_masked;
            r_p    <= in_last ? '1 : w_present;
            r_e    <= in_last ? ~w_present : '0;
            r_l    <= in_last;
            r_full <= in_last | (w_present != '0);
         end else begin
            r_p    <= w_p_next;
            r_full <= w_p_next != '0;
         end
      end
   end
endmodule

// File: tb/tb_axi_to_conv_stream.sv
// tb_axi_to_conv_stream: table vectors, directed corner sequences and a randomized run
// compared against a lane-level reference model.
module tb_axi_to_conv_stream;
   localparam int BS = 128, NB = 8, DW = NB*BS, KB = BS/8, KW = DW/8;
   logic clk = 1'b0, rst_n;
   logic in_ready, in_valid, in_last, keep_err;
   logic [DW-1:0] in_data;
   logic [KW-1:0] in_keep;
   logic [NB-1:0] out_ready, out_valid, out_last, out_empty;
   logic [NB-1:0][BS-1:0] out_data;
   logic [31:0] pkt_count;
   int checks = 0, errors = 0;

   logic [BS-1:0] m_blk [NB];
   logic [NB-1:0] m_pend, m_empty;
   logic m_last, m_kerr;
   logic [31:0] m_cnt;

   typedef struct {
      logic [KW-1:0] keep;
      logic last;
      logic [NB-1:0] ev, el, ee;
      logic ir;
   } vec_t;
   vec_t tv [6];

   axi_to_conv_stream #(.BLOCK_SIZE(BS), .NUM_BLOCKS(NB)) dut (
      .clk(clk), .rst_n(rst_n), .in_ready(in_ready), .in_data(in_data), .in_keep(in_keep),
      .in_valid(in_valid), .in_last(in_last), .out_ready(out_ready), .out_data(out_data),
      .out_valid(out_valid), .out_last(out_last), .out_empty(out_empty),
      .pkt_count(pkt_count), .keep_err(keep_err)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", n, a, e);
      end
   endtask

   function automatic logic m_rdy();
      return rst_n && ((m_pend & ~out_ready) == '0);
   endfunction

   task automatic m_reset();
      m_pend = '0; m_empty = '0; m_last = 1'b0; m_kerr = 1'b0; m_cnt = '0;
      for (int i = 0; i < NB; i++) m_blk[i] = '0;
   endtask

   task automatic model_edge();
      logic rdy, had, bad;
      logic [NB-1:0] pres;
      int k;
      rdy = m_rdy();
      had = m_pend != '0;
      m_pend &= ~out_ready;
      if (m_last && had && m_pend == '0) m_cnt++;
      if (in_valid && rdy) begin
         pres = '0;
         for (int i = 0; i < NB; i++)
            for (int b = 0; b < KB; b++) begin
               pres[i] |= in_keep[i*KB+b];
               m_blk[i][b*8 +: 8] = in_keep[i*KB+b] ? in_data[(i*KB+b)*8 +: 8] : 8'h00;
            end
         k = 0;
         while (k < KW && in_keep[k]) k++;
         bad = 1'b0;
         for (int j = k; j < KW; j++) bad |= in_keep[j];
         if (bad) m_kerr = 1'b1;
         m_pend  = in_last ? '1 : pres;
         m_empty = in_last ? ~pres : '0;
         m_last  = in_last;
      end
   endtask

   task automatic check_model();
      chk("in_ready", in_ready, m_rdy());
      chk("out_valid", out_valid, m_pend);
      chk("out_last", out_last, m_pend & {NB{m_last}});
      chk("out_empty", out_empty, m_pend & m_empty);
      chk("pkt_count", pkt_count, m_cnt);
      chk("keep_err", keep_err, m_kerr);
      for (int i = 0; i < NB; i++)
         if (m_pend[i]) chk($sformatf("out_data[%0d]", i), out_data[i], m_blk[i]);
   endtask

   task automatic step();
      #1 check_model();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      m_reset();
      chk("rst_ready", in_ready, 1'b0);
      chk("rst_valid", out_valid, '0);
      chk("rst_last", out_last, '0);
      chk("rst_empty", out_empty, '0);
      chk("rst_pkt", pkt_count, 32'd0);
      chk("rst_kerr", keep_err, 1'b0);
      for (int i = 0; i < NB; i++) chk($sformatf("rst_data[%0d]", i), out_data[i], '0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [DW-1:0] d0, d1;
      int exp_pkts, lane, r;
      rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_keep = '0; in_data = '0; out_ready = '0;
      tv[0] = '{keep: {KW{1'b1}},        last: 1'b0, ev: 8'hFF, el: 8'h00, ee: 8'h00, ir: 1'b0};
      tv[1] = '{keep: 128'hFFFF_FFFF,    last: 1'b1, ev: 8'hFF, el: 8'hFF, ee: 8'hFC, ir: 1'b0};
      tv[2] = '{keep: 128'hF,            last: 1'b0, ev: 8'h01, el: 8'h00, ee: 8'h00, ir: 1'b0};
      tv[3] = '{keep: 128'h0,            last: 1'b0, ev: 8'h00, el: 8'h00, ee: 8'h00, ir: 1'b1};
      tv[4] = '{keep: 128'h0,            last: 1'b1, ev: 8'hFF, el: 8'hFF, ee: 8'hFF, ir: 1'b0};
      tv[5] = '{keep: 128'hFFFF_0000,    last: 1'b0, ev: 8'h02, el: 8'h00, ee: 8'h00, ir: 1'b0};
      #1 do_reset();

      exp_pkts = 0;
      for (int t = 0; t < 6; t++) begin
         in_valid = 1'b1; in_keep = tv[t].keep; in_last = tv[t].last; in_data = rand_data();
         out_ready = '0;
         step();
         in_valid = 1'b0;
         #1;
         chk($sformatf("tbl%0d_valid", t), out_valid, tv[t].ev);
         chk($sformatf("tbl%0d_last", t), out_last, tv[t].el);
         chk($sformatf("tbl%0d_empty", t), out_empty, tv[t].ee);
         chk($sformatf("tbl%0d_ready", t), in_ready, tv[t].ir);
         if (t == 2) chk("tbl2_lane0_hi", out_data[0][BS-1:32], '0);
         if (t == 1) for (int i = 2; i < NB; i++) chk($sformatf("tbl1_zero%0d", i), out_data[i], '0);
         out_ready = '1;
         step();
         step();
         if (tv[t].last) exp_pkts++;
         chk($sformatf("tbl%0d_pkt", t), pkt_count, exp_pkts);
      end

      // back-to-back full beats with all lanes ready
      out_ready = '1; in_valid = 1'b1; in_last = 1'b0; in_keep = '1;
      for (int n = 0; n < 4; n++) begin
         in_data = rand_data();
         #1 chk("b2b_ready", in_ready, 1'b1);
         step();
         chk("b2b_valid", out_valid, 8'hFF);
      end
      in_valid = 1'b0;
      step();

      // partial lane drain: lanes 4-7 hold, then reload with no bubble
      d0 = rand_data(); d1 = rand_data();
      in_valid = 1'b1; in_keep = '1; in_last = 1'b0; in_data = d0; out_ready = '0;
      step();
      in_data = d1; out_ready = 8'h0F;
      for (int n = 0; n < 3; n++) begin
         #1 chk("hold_ready", in_ready, 1'b0);
         step();
         chk("hold_valid", out_valid, 8'hF0);
         chk("hold_data4", out_data[4], d0[4*BS +: BS]);
         chk("hold_data7", out_data[7], d0[7*BS +: BS]);
      end
      out_ready = 8'hFF;
      #1 chk("release_ready", in_ready, 1'b1);
      step();
      chk("reload_valid", out_valid, 8'hFF);
      chk("reload_data0", out_data[0], d1[BS-1:0]);
      chk("reload_data5", out_data[5], d1[5*BS +: BS]);
      in_valid = 1'b0;
      step();

      // keep_err is sticky across clean beats and cleared only by reset
      in_valid = 1'b1; in_keep = '1; in_data = rand_data();
      step(); step();
      chk("kerr_sticky", keep_err, 1'b1);
      in_valid = 1'b0;
      do_reset();
      in_valid = 1'b1; in_keep = 128'hFF00; in_data = rand_data();
      step();
      chk("kerr_set", keep_err, 1'b1);
      in_keep = '1;
      step(); step();
      in_valid = 1'b0;
      step();
      chk("kerr_hold", keep_err, 1'b1);

      // reset while lanes 5-7 are still pending
      in_valid = 1'b1; in_keep = '1; in_last = 1'b1; in_data = rand_data(); out_ready = '0;
      step();
      in_valid = 1'b0; in_last = 1'b0; out_ready = 8'h1F;
      step();
      out_ready = '0;
      step();
      chk("pre_rst_valid", out_valid, 8'hE0);
      #2 rst_n = 1'b0;
      #1;
      m_reset();
      chk("mid_rst_valid", out_valid, '0);
      chk("mid_rst_last", out_last, '0);
      chk("mid_rst_ready", in_ready, 1'b0);
      chk("mid_rst_data5", out_data[5], '0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = '1;
      step(); step();
      chk("post_rst_pkt", pkt_count, 32'd0);
      chk("post_rst_valid", out_valid, '0);

      // randomized traffic against the reference model
      for (int n = 0; n < 3000; n++) begin
         in_valid = ($urandom % 3) != 0;
         in_last = ($urandom % 4) == 0;
         in_data = rand_data();
         r = $urandom % 8;
         in_keep = '0;
         if (r < 3) in_keep = '1;
         else if (r < 5) begin
            lane = $urandom_range(0, KW);
            for (int j = 0; j < lane; j++) in_keep[j] = 1'b1;
         end else if (r == 6) begin
            for (int j = 0; j < KW/32; j++) in_keep[j*32 +: 32] = $urandom;
         end else if (r == 7) begin
            lane = $urandom % NB;
            r = $urandom_range(1, KB);
            for (int j = 0; j < r; j++) in_keep[lane*KB+j] = 1'b1;
         end
         out_ready = ($urandom % 2) ? '1 : NB'($urandom);
         step();
      end
      in_valid = 1'b0; out_ready = '1;
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/axi_to_conv_stream.md
AXI_TO_CONV_STREAM -- requirements
Module: axi_to_conv_stream

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 128; the width of one lane block in bits (multiple of 8).
REQ-002 SHALL have parameter NUM_BLOCKS, default 8; the number of output lanes; AXI data width = NUM_BLOCKS*BLOCK_SIZE.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_ready  output  1  AXI-stream ready toward the upstream.
REQ-006 SHALL have port in_data  input  NUM_BLOCKS*BLOCK_SIZE  AXI beat data; block i = bits [i*BLOCK_SIZE +: BLOCK_SIZE].
REQ-007 SHALL have port in_keep  input  NUM_BLOCKS*BLOCK_SIZE/8  byte enables; keep group i = bits [i*BLOCK_SIZE/8 +: BLOCK_SIZE/8].
REQ-008 SHALL have port in_valid  input  1  AXI beat valid.
REQ-009 SHALL have port in_last  input  1  final beat of packet.
REQ-010 SHALL have port out_ready  input  [NUM_BLOCKS-1:0]  per-lane ready.
REQ-011 SHALL have port out_data  output  [NUM_BLOCKS-1:0][BLOCK_SIZE-1:0]  per-lane block.
REQ-012 SHALL have port out_valid  output  [NUM_BLOCKS-1:0]  per-lane valid.
REQ-013 SHALL have port out_last  output  [NUM_BLOCKS-1:0]  per-lane end of packet.
REQ-014 SHALL have port out_empty  output  [NUM_BLOCKS-1:0]  lane block is a last-only marker with no payload.
REQ-015 SHALL have port pkt_count  output  32  packets fully delivered since reset, wraps 2^32-1 -> 0.
REQ-016 SHALL have port keep_err  output  1  sticky: accepted beat had non-prefix keep.

Function
REQ-017 SHALL hold one beat register: data, per-lane pending mask P[NUM_BLOCKS-1:0], per-lane empty mask E, last flag L, full flag.
REQ-018 Beat accepted on in_valid & in_ready; block i present if any bit of keep group i is 1.
REQ-019 On accept: stored block i = in_data block with every byte whose keep bit is 0 forced to 0x00.
REQ-020 On accept with in_last=0: P = present mask, E = 0; if present mask = 0, beat is dropped (full stays 0, no output).
REQ-021 On accept with in_last=1: P = all ones, E = ~present mask, L = 1; absent lanes carry zero data.
REQ-022 out_valid[i] = full & P[i]; out_last[i] = full & P[i] & L; out_empty[i] = full & P[i] & E[i]; out_data driven from register.
REQ-023 Lanes independent: lane i handshake (out_valid[i] & out_ready[i]) clears P[i] at the edge; other lanes unaffected.
REQ-024 in_ready = rst_n & (~full | ((P & ~out_ready) == 0)); combinational path from out_ready to in_ready permitted.
REQ-025 When the final pending lanes handshake and a new beat is accepted in the same cycle, the register loads the new beat with no bubble.
REQ-026 Delivery latency: accepted beat appears on out_valid the cycle after acceptance.
REQ-027 pkt_count increments by 1 in the cycle the last pending lane of an L=1 beat handshakes.
REQ-028 keep_err sets on accepted beat whose keep is not of form 2^k-1 (k=0..full width); beat still processed per REQ-019..021; cleared only by reset.
REQ-029 Once asserted, out_valid[i] and out_data[i] SHALL remain stable until lane i handshakes.

Reset
REQ-030 rst_n low asynchronously: full=0, P=0, E=0, L=0, pkt_count=0, keep_err=0; all outputs 0 including in_ready.
REQ-031 Reset mid-operation SHALL discard the held beat with no lane handshake completed afterward.
REQ-032 First beat accepted on the first rising edge with rst_n high and in_valid=1.

Verification
REQ-033 Full beat, keep=all ones, in_last=0, all out_ready=1 -> next cycle out_valid=8'hFF, lane i data = input block i, out_last=0, in_ready stays 1, back-to-back beats at one per cycle.
REQ-034 keep=128'h0000_..._FFFF_FFFF (32 bytes), in_last=1 -> out_valid=8'hFF, out_last=8'hFF, out_empty=8'hFC, lanes 2-7 data 0; pkt_count 0->1 after all lanes handshake.
REQ-035 out_ready=8'h0F for 3 cycles then 8'hFF -> lanes 0-3 complete cycle 1, lanes 4-7 held stable, in_ready=0 until cycle lanes 4-7 handshake, then new beat loaded same cycle.
REQ-036 keep=128'h00..0F (4 bytes), in_last=0 -> out_valid=8'h01, lane 0 data bytes 4-15 zero; keep=0 in_last=0 -> no output, in_ready remains 1.
REQ-037 keep=128'h...FF00 (non-prefix) -> keep_err=1 and stays 1 across later clean beats until rst_n pulse.
REQ-038 rst_n low while lanes 5-7 pending -> outputs all 0 immediately, pkt_count unchanged at 0 after release, no stale out_valid.
